// File: rtl/uart_frame_accumulator.sv
// Byte-stream frame collector: closes a frame on a two-byte terminator, a CR
// terminator or a length prefix, and holds DONE/ERROR until released.
module uart_frame_accumulator #(
  parameter int         MAX_BYTES = 128,
  parameter int         TIMEOUT   = 1026,
  parameter logic [7:0] TERM_HI   = 8'hBE,
  parameter logic [7:0] TERM_LO   = 8'hEF,
  parameter logic [7:0] TERM_CR   = 8'h0D,
  localparam int        SW        = $clog2(MAX_BYTES + 1),
  localparam int        TW        = $clog2(TIMEOUT + 1),
  localparam int        IW        = $clog2(MAX_BYTES * 8)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_reset,
  input  logic [7:0]             input_data,
  input  logic                   accumulate,
  input  logic [1:0]             mode,
  input  logic                   frame_release,
  output logic [MAX_BYTES*8-1:0] output_data,
  output logic [SW-1:0]          output_data_size,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             error_code,
  output logic                   busy
);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_PEND, S_LEN, S_DONE, S_ERROR} state_t;

  state_t          state, state_n;
  logic [1:0]      mode_q, mode_n, eff_mode, code_n;
  logic [SW-1:0]   len_q, len_n, size_n;
  logic [TW-1:0]   timer, timer_n;
  logic            clear, wr0, wr1, full;
  logic [7:0]      b0;
  logic [IW-1:0]   ptr0, ptr1;

  // A frame's mode comes from the pin only on its first byte.
  assign eff_mode = (state == S_IDLE) ? ((mode == 2'd3) ? 2'd0 : mode) : mode_q;
  assign full     = (output_data_size == SW'(MAX_BYTES));
  assign b0       = (state == S_PEND) ? TERM_HI : input_data;
  assign ptr0     = IW'({output_data_size, 3'b000});
  assign ptr1     = ptr0 + IW'(8);

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    len_n   = len_q;
    size_n  = output_data_size;
    code_n  = error_code;
    timer_n = timer;
    wr0     = 1'b0;
    wr1     = 1'b0;
    clear   = soft_reset || (frame_release && (state == S_DONE || state == S_ERROR));
    if (clear || state == S_DONE || state == S_ERROR) begin
      state_n = state;
    end else if (accumulate) begin
      timer_n = '0;
      mode_n  = eff_mode;
      if (state == S_IDLE && eff_mode == 2'd2) begin
        if (input_data == 8'd0) begin
          state_n = S_DONE;
        end else if (int'(input_data) > MAX_BYTES) begin
          state_n = S_ERROR;
          code_n  = 2'd3;
        end else begin
          len_n   = SW'(input_data);
          state_n = S_LEN;
        end
      end else if (state == S_LEN) begin
        wr0    = 1'b1;
        size_n = output_data_size + SW'(1);
        if (size_n == len_q) state_n = S_DONE;
      end else if (state == S_PEND) begin
        if (input_data == TERM_LO) begin
          state_n = S_DONE;
        end else if (full) begin
          state_n = S_ERROR;
          code_n  = 2'd1;
        end else begin
          // Held TERM_HI turns into payload; a non-HI byte follows it in the same cycle.
          wr0    = 1'b1;
          size_n = output_data_size + SW'(1);
          if (input_data != TERM_HI) begin
            if (output_data_size == SW'(MAX_BYTES - 1)) begin
              state_n = S_ERROR;
              code_n  = 2'd1;
            end else begin
              wr1     = 1'b1;
              size_n  = output_data_size + SW'(2);
              state_n = S_RECV;
            end
          end
        end
      end else if (eff_mode == 2'd0 && input_data == TERM_HI) begin
        state_n = S_PEND;
      end else if (eff_mode == 2'd1 && input_data == TERM_CR) begin
        state_n = S_DONE;
      end else if (full) begin
        state_n = S_ERROR;
        code_n  = 2'd1;
      end else begin
        wr0     = 1'b1;
        size_n  = output_data_size + SW'(1);
        state_n = S_RECV;
      end
    end else if (state != S_IDLE) begin
      if (timer == TW'(TIMEOUT - 1)) begin
        state_n = S_ERROR;
        code_n  = 2'd2;
        timer_n = '0;
      end else begin
        timer_n = timer + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state            <= S_IDLE;
      mode_q           <= '0;
      len_q            <= '0;
      timer            <= '0;
      output_data      <= '0;
      output_data_size <= '0;
      error_code       <= '0;
    end else begin
      state            <= state_n;
      mode_q           <= mode_n;
      len_q            <= len_n;
      timer            <= timer_n;
      output_data_size <= size_n;
      error_code       <= code_n;
      if (wr0) output_data[ptr0 +: 8] <= b0;
      if (wr1) output_data[ptr1 +: 8] <= input_data;
    end
  end

  assign done  = (state == S_DONE);
  assign error = (state == S_ERROR);
  assign busy  = (state == S_RECV) || (state == S_PEND) || (state == S_LEN);

endmodule
